// File: rtl/div_pkg.sv
// div_pkg: shared width default, FSM state type and constants for the sequential divider
package div_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);
    localparam logic [63:0] DIV0_QUOTIENT = '1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/seq_div8_cla_sub.sv
// cla_sub: combinational N-bit carry-lookahead subtractor, a-b as a+~b+1
module cla_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N-1:0] g, p;
    logic [N:0] c;
    logic acc, pp;
    assign g = a & ~b;
    assign p = a ^ ~b;
    // each carry is expanded as a flat generate/propagate sum back to the +1 carry-in
    always_comb begin
        c = '0;
        acc = 1'b0;
        pp = 1'b0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = acc | pp;
        end
    end
    assign diff = p ^ c[N-1:0];
    assign borrow = ~c[N];
endmodule

// File: rtl/seq_div8.sv
// seq_div8: restoring divider, one quotient bit per clock; SEQ_DIV_SIGNED_EN selects two's-complement operands
module seq_div8
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    div_state_t state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d;
    logic [WIDTH:0] rs, diff;
    logic borrow, unused_diff_msb;
    logic [WIDTH-1:0] q_nxt, r_nxt, dvd_l, dvs_l, quo_f, rem_f;
`ifdef SEQ_DIV_SIGNED_EN
    logic sq_q, sq_d, sr_q, sr_d;
    assign dvd_l = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_l = divisor[WIDTH-1] ? -divisor : divisor;
    assign quo_f = sq_q ? -q_nxt : q_nxt;
    assign rem_f = sr_q ? -r_nxt : r_nxt;
`else
    assign dvd_l = dividend;
    assign dvs_l = divisor;
    assign quo_f = q_nxt;
    assign rem_f = r_nxt;
`endif
    // the partial remainder never reaches the divisor, so its top bit is always zero and is not stored
    assign rs = {r_q, q_q[WIDTH-1]};
    cla_sub #(.N(WIDTH + 1)) u_sub (
        .a(rs),
        .b({1'b0, dvs_q}),
        .diff(diff),
        .borrow(borrow)
    );
    assign unused_diff_msb = diff[WIDTH];
    assign r_nxt = borrow ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_nxt = {q_q[WIDTH-2:0], ~borrow};
    assign busy = state_q == BUSY;
    assign done = state_q == DONE;
    assign quotient = quo_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
    // next state: accept start in IDLE, iterate in BUSY, single-cycle DONE
    always_comb begin
        state_d = state_q;
        r_d = r_q;
        q_d = q_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        sq_d = sq_q;
        sr_d = sr_q;
`endif
        if (state_q == IDLE && start) begin
            r_d = '0;
            q_d = dvd_l;
            dvs_d = dvs_l;
            cnt_d = '0;
`ifdef SEQ_DIV_SIGNED_EN
            sq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr_d = dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
                state_d = DONE;
                quo_d = WIDTH'(DIV0_QUOTIENT);
                rem_d = dividend;
                dbz_d = 1'b1;
            end else begin
                state_d = BUSY;
            end
        end else if (state_q == BUSY) begin
            r_d = r_nxt;
            q_d = q_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                quo_d = quo_f;
                rem_d = rem_f;
                dbz_d = 1'b0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q <= '0;
            q_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sq_q <= 1'b0;
            sr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q <= r_d;
            q_q <= q_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            sq_q <= sq_d;
            sr_q <= sr_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: scoreboard bench for seq_div8 with an arithmetic reference model
module tb_seq_div8;
    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         st;
        int         dc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
    int cyc = 0, nchk = 0, nfail = 0;
    exp_t sb[$];
    exp_t cur;
    logic [7:0] hq = '0, hr = '0;
    logic hz = 1'b0;
    logic exp_done, exp_busy;

    seq_div8 dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, int st);
        exp_t e;
        e.st = st;
        e.z = (b == 8'd0);
        e.dc = st + (e.z ? 0 : 8);
        if (e.z) begin
            e.q = 8'hFF;
            e.r = a;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            int x, y;
            x = int'($signed(a));
            y = int'($signed(b));
            e.q = 8'(x / y);
            e.r = 8'(x % y);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    // monitor: compare handshake timing every cycle, pop the scoreboard on done
    always @(negedge clk) begin
        exp_done = sb.size() > 0 && cyc == sb[0].dc;
        exp_busy = sb.size() > 0 && !sb[0].z && cyc >= sb[0].st && cyc < sb[0].dc;
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (exp_done || done) begin
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                hq = cur.q;
                hr = cur.r;
                hz = cur.z;
            end
        end
        chk("quotient", 32'(quotient), 32'(hq));
        chk("remainder", 32'(remainder), 32'(hr));
        chk("div_by_zero", 32'(div_by_zero), 32'(hz));
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic issue(logic [7:0] a, logic [7:0] b);
        wait_idle();
        dividend = a;
        divisor = b;
        start = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_ignored(logic [7:0] a, logic [7:0] b);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        hq = '0;
        hr = '0;
        hz = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(8'd200, 8'd7);
        issue(8'd5, 8'd9);
        issue(8'd255, 8'd1);
        issue(8'd13, 8'd0);
        issue(8'd100, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        pulse_ignored(8'd50, 8'd5);
        issue(8'd17, 8'd4);
        issue(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        issue(8'd9, 8'd2);
        issue(8'd0, 8'd0);
        issue(8'd0, 8'd255);
        issue(8'd255, 8'd255);
`ifdef SEQ_DIV_SIGNED_EN
        issue(8'h9C, 8'd7);
        issue(8'h80, 8'hFF);
        issue(8'd100, 8'hF9);
        issue(8'h80, 8'h01);
`endif
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
